// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states
// and the bit positions of the NZCV flags.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Operand and result handshake bundle of the sequential ALU. The master side
// is the operand source / result consumer, the slave side is the ALU itself.
interface alu_seq_unit_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [2:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic [3:0]    flags;
  logic [CW-1:0] op_count;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags, op_count
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags, op_count
  );
endinterface

// File: rtl/alu_seq_unit_mul.sv
// Unsigned shift-add multiplier: loads on start, performs one add/shift step
// per cycle for N cycles, then pulses done for one cycle with product valid.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CNTW = $clog2(N) + 1;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic [N-1:0]    mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (busy_q) begin
      // Multiplier bits consumed LSB first while the multiplicand walks left.
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
      if (cnt_q == CNTW'(N - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with operand/result handshakes, multi-cycle multiply,
// NZCV flags and a wrapping count of consumed results.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input logic           clk,
  input logic           rst,
  alu_seq_unit_if.slave bus
);
  localparam int SW = $clog2(N);

  state_e        state_q, state_d;
  opcode_e       op_q, op_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;

  logic           in_ready, out_valid, accept, mul_start, load_res, consume;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic [3:0]     alu_flags;
  logic [N:0]     wide;
  logic [SW-1:0]  sh_amt;

  seq_multiplier #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)
                 state_d = (opcode_e'(bus.opcode) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (mul_done) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    accept    = in_ready && bus.in_valid;
    mul_start = accept && (opcode_e'(bus.opcode) == OP_MUL);
    load_res  = (state_q == ST_EXEC) || ((state_q == ST_MUL) && mul_done);
    consume   = out_valid && bus.out_ready;
  end

  // Shifts go through an N+1 bit window so the bit shifted out lands in
  // the spare position; an amount of zero leaves that position clear.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    sh_amt  = b_q[SW-1:0];
    case (op_q)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q >= b_q);
        alu_v   = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        wide    = {1'b0, a_q} << sh_amt;
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
      end
      OP_SHR: begin
        wide    = {a_q, 1'b0} >> sh_amt;
        alu_res = wide[N:1];
        alu_c   = wide[0];
      end
      OP_MUL: begin
        alu_res = mul_product[N-1:0];
        alu_c   = |mul_product[2*N-1:N];
        alu_v   = alu_c;
      end
      default: alu_res = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[N-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;
    if (accept) begin
      op_d = opcode_e'(bus.opcode);
      a_d  = bus.a;
      b_d  = bus.b;
    end
    if (load_res) begin
      result_d = alu_res;
      flags_d  = alu_flags;
    end
    if (consume) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised scoreboard bench for alu_seq_unit: the driver queues expected
// results at acceptance, a monitor pops and compares at each result handshake.
module tb_alu_seq_unit;
  localparam int N  = 8;
  localparam int CW = 8;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.N(N), .CW(CW)) bus ();

  alu_seq_unit #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   exp_count  = 0;
  int   handshakes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented op rules.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int r, c, v, sa, sb, sr, sh, p;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; sr = sa + sb;
               v = (sr > 127 || sr < -128) ? 1 : 0; r = r % 256; end
      1: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; sr = sa - sb;
               v = (sr > 127 || sr < -128) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) % 256; c = (sh != 0) ? ((a >> (8 - sh)) & 1) : 0; end
      6: begin r = a >> sh; c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
      default: begin p = a * b; r = p % 256; c = (p > 255) ? 1 : 0; v = c; end
    endcase
    e.res = 8'(r);
    e.flg = {(r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0]};
    return e;
  endfunction

  // Monitor: compares at every result handshake and tracks op_count.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", int'(bus.result), int'(e.res));
          check("flags", int'(bus.flags), int'(e.flg));
          check("op_count", int'(bus.op_count), exp_count);
          $display("txn %0d result=0x%02h flags=%04b op_count=%0d",
                   handshakes, bus.result, bus.flags, bus.op_count);
          exp_count = (exp_count + 1) % 256;
          handshakes++;
        end
      end
    end
  end

  task automatic run_op(input int a, input int b, input int op, input exp_t e, input int hold);
    int lat, want;
    bit got;
    logic [7:0] held_r;
    logic [3:0] held_f;
    want = (op == 7) ? N + 1 : 1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = a[7:0];
    bus.b         = b[7:0];
    bus.opcode    = op[2:0];
    bus.out_ready = (hold == 0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1; break; end
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (hold > 0) begin
      bus.a      = 8'($urandom);
      bus.b      = 8'($urandom);
      bus.opcode = 3'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    lat = 0; got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin lat = k; got = 1; break; end
      check("in_ready_busy", int'(bus.in_ready), 0);
    end
    check("latency", lat, want);
    if (got && hold > 0) begin
      held_r = bus.result;
      held_f = bus.flags;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_result", int'(bus.result), int'(held_r));
        check("hold_flags", int'(bus.flags), int'(held_f));
        check("hold_in_ready", int'(bus.in_ready), 0);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t e;
    int a, b, op, seen;
    int dir_a[7] = '{8'h7F, 8'h05, 8'h03, 8'h81, 8'h81, 8'h10, 8'h0C};
    int dir_b[7] = '{8'h01, 8'h05, 8'h05, 8'h01, 8'h09, 8'h10, 8'h0B};
    int dir_o[7] = '{0, 1, 1, 5, 6, 7, 7};
    int dir_r[7] = '{8'h80, 8'h00, 8'hFE, 8'h02, 8'h40, 8'h00, 8'h84};
    int dir_f[7] = '{4'b1001, 4'b0110, 4'b1000, 4'b0010, 4'b0010, 4'b0111, 4'b1000};

    // Reset with in_valid and out_ready both asserted.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.a         = 8'h12;
    bus.b         = 8'h34;
    bus.opcode    = 3'd0;
    rst           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_flags", int'(bus.flags), 0);
    check("rst_op_count", int'(bus.op_count), 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_no_accept", int'(bus.out_valid), 0);

    // Reset in the middle of a multiply discards it.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 8'h03; bus.b = 8'h05; bus.opcode = 3'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_count = 0;
    @(negedge clk);
    check("midmul_in_ready", int'(bus.in_ready), 1);
    check("midmul_op_count", int'(bus.op_count), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("midmul_no_result", seen, 0);

    // Directed corner cases with hand-derived expectations.
    for (int i = 0; i < 7; i++) begin
      e.res = 8'(dir_r[i]);
      e.flg = 4'(dir_f[i]);
      run_op(dir_a[i], dir_b[i], dir_o[i], e, 0);
    end

    // Backpressure: result held five cycles while junk operands are offered.
    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    run_op(a, b, 0, model(a, b, 0), 5);
    @(posedge clk);
    @(negedge clk);
    check("bp_op_count", int'(bus.op_count), exp_count);

    // Random traffic until 256 results are consumed.
    while (handshakes < 256) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 7));
      run_op(a, b, op, model(a, b, op), ($urandom_range(0, 7) == 0) ? 2 : 0);
    end
    @(posedge clk);
    @(negedge clk);
    check("op_count_wrap", int'(bus.op_count), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
